// File: rtl/alu_sequencer.sv
// alu_sequencer
//   Accepts one command at a time, registers it onto the operand bus of an
//   external ALU, gives the ALU one cycle to settle, then captures
//   {opcode, carry, result} into a small result FIFO for a downstream consumer.
//
// Ports
//   Clk, RstN            clock, asynchronous active-low reset
//   CmdValid/CmdReady    command handshake
//   CmdOpCode,CmdA,CmdB  command fields
//   OpCode,InputA,InputB registered command driven to the ALU
//   OutALU, COut         ALU result and carry/borrow
//   ResValid/ResReady    result handshake (head of FIFO)
//   ResData,ResCarry,ResOpCode  head entry fields
//   ResCount             FIFO occupancy
module alu_sequencer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     Clk,
  input  logic                     RstN,
  input  logic                     CmdValid,
  output logic                     CmdReady,
  input  logic [2:0]               CmdOpCode,
  input  logic [7:0]               CmdA,
  input  logic [7:0]               CmdB,
  output logic [2:0]               OpCode,
  output logic [7:0]               InputA,
  output logic [7:0]               InputB,
  input  logic [15:0]              OutALU,
  input  logic                     COut,
  output logic                     ResValid,
  input  logic                     ResReady,
  output logic [15:0]              ResData,
  output logic                     ResCarry,
  output logic [2:0]               ResOpCode,
  output logic [$clog2(DEPTH):0]   ResCount
);

  localparam int unsigned PTRW = $clog2(DEPTH);
  localparam int unsigned CNTW = PTRW + 1;

  typedef enum logic [1:0] {IDLE, EXEC, WRITE} stateT;

  stateT            state;
  stateT            nextState;
  logic             cmdAccept;
  logic             push;
  logic             pop;
  logic [PTRW-1:0]  wrPtr;
  logic [PTRW-1:0]  rdPtr;
  logic [19:0]      mem [DEPTH];

  assign CmdReady = (state == IDLE) && (ResCount < CNTW'(DEPTH));
  assign ResValid = (ResCount != '0);
  assign push     = (state == WRITE);
  assign pop      = ResValid && ResReady;

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    cmdAccept = 1'b0;
    unique case (state)
      IDLE: begin
        if (CmdValid && CmdReady) begin
          cmdAccept = 1'b1;
          nextState = EXEC;
        end
      end
      EXEC:    nextState = WRITE;
      WRITE:   nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Operand registers hold until the next accepted command.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      OpCode <= '0;
      InputA <= '0;
      InputB <= '0;
    end else if (cmdAccept) begin
      OpCode <= CmdOpCode;
      InputA <= CmdA;
      InputB <= CmdB;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      ResCount <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + PTRW'(1);
      if (pop)  rdPtr <= rdPtr + PTRW'(1);
      unique case ({push, pop})
        2'b10:   ResCount <= ResCount + CNTW'(1);
        2'b01:   ResCount <= ResCount - CNTW'(1);
        default: ResCount <= ResCount;
      endcase
    end
  end

  // Storage is not reset; the head fields are meaningless while empty.
  always_ff @(posedge Clk) begin
    if (push) mem[wrPtr] <= {OpCode, COut, OutALU};
  end

  assign {ResOpCode, ResCarry, ResData} = mem[rdPtr];

endmodule
